// File: rtl/wb_merge_if.sv
// Completion-source and register-file write bundle for wb_merge.
// The master side produces completions and observes the regfile write; the slave side is the merge unit.
interface wb_merge_if #(
  parameter int XLEN    = 32,
  parameter int NUM_SRC = 2
);
  localparam int OFFW = $clog2(XLEN / 8);

  logic [NUM_SRC-1:0]           src_valid;
  logic [NUM_SRC-1:0]           src_ready;
  logic [NUM_SRC-1:0][4:0]      src_rd;
  logic [NUM_SRC-1:0][XLEN-1:0] src_data;
  logic [NUM_SRC-1:0]           src_is_load;
  logic [NUM_SRC-1:0][2:0]      src_funct3;
  logic [NUM_SRC-1:0][OFFW-1:0] src_off;

  logic                         rf_we;
  logic [4:0]                   rf_rd;
  logic [XLEN-1:0]              rf_data;

  modport master (
    output src_valid, src_rd, src_data, src_is_load, src_funct3, src_off,
    input  src_ready, rf_we, rf_rd, rf_data
  );

  modport slave (
    input  src_valid, src_rd, src_data, src_is_load, src_funct3, src_off,
    output src_ready, rf_we, rf_rd, rf_data
  );
endinterface

// File: rtl/wb_merge.sv
// Write-back merge: per-source completion FIFOs, round-robin pick of one head per cycle,
// load byte/half/word extraction, and a registered single-port regfile write.
module wb_merge #(
  parameter int XLEN    = 32,
  parameter int NUM_SRC = 2,
  parameter int DEPTH   = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  wb_merge_if.slave    bus
);
  localparam int OFFW = $clog2(XLEN / 8);
  localparam int PTRW = $clog2(DEPTH);
  localparam int CNTW = $clog2(DEPTH + 1);
  localparam int RRW  = $clog2(NUM_SRC);

  localparam logic [CNTW-1:0] FULL_CNT = CNTW'(DEPTH);
  localparam logic [RRW:0]    NSRC     = (RRW + 1)'(NUM_SRC);
  localparam logic [RRW-1:0]  LAST_SRC = RRW'(NUM_SRC - 1);

  typedef struct packed {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
    logic            is_load;
    logic [2:0]      funct3;
    logic [OFFW-1:0] off;
  } entry_t;

  entry_t          mem    [NUM_SRC][DEPTH];
  logic [PTRW-1:0] wr_ptr [NUM_SRC];
  logic [PTRW-1:0] rd_ptr [NUM_SRC];
  logic [CNTW-1:0] count  [NUM_SRC];
  logic [RRW-1:0]  rr_ptr;

  logic [NUM_SRC-1:0] ready;
  logic [NUM_SRC-1:0] push;
  logic [NUM_SRC-1:0] pop;
  logic               grant_valid;
  logic [RRW-1:0]     grant_idx;
  logic [RRW:0]       cand;
  entry_t             head;

  logic               we_q;
  logic [4:0]         rd_q;
  logic [XLEN-1:0]    data_q;

  // Ready looks only at stored occupancy, so a full FIFO refuses even when it is popped this cycle.
  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      ready[i] = (count[i] < FULL_CNT);
    end
  end

  assign push          = bus.src_valid & ready & {NUM_SRC{~flush}};
  assign bus.src_ready = ready;

  // NOTE: every always_comb output gets a default before any branch; otherwise a latch is inferred.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    pop         = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      cand = {1'b0, rr_ptr} + (RRW + 1)'(k);
      if (cand >= NSRC) cand = cand - NSRC;
      if (!grant_valid && count[cand[RRW-1:0]] != '0) begin
        grant_valid = 1'b1;
        grant_idx   = cand[RRW-1:0];
      end
    end
    if (flush) grant_valid = 1'b0;
    if (grant_valid) pop[grant_idx] = 1'b1;
  end

  assign head = mem[grant_idx][rd_ptr[grant_idx]];

  function automatic logic [XLEN-1:0] extract(input entry_t e);
    logic [OFFW-1:0] off_h;
    logic [OFFW-1:0] off_w;
    logic [XLEN-1:0] sh_b;
    logic [XLEN-1:0] sh_h;
    logic [XLEN-1:0] sh_w;
    off_h      = e.off;
    off_h[0]   = 1'b0;
    off_w      = e.off;
    off_w[1:0] = 2'b00;
    sh_b       = e.data >> {e.off, 3'b000};
    sh_h       = e.data >> {off_h, 3'b000};
    sh_w       = e.data >> {off_w, 3'b000};
    extract    = e.data;
    if (e.is_load) begin
      case (e.funct3)
        3'b000: extract = XLEN'($signed(sh_b[7:0]));
        3'b100: extract = XLEN'(sh_b[7:0]);
        3'b001: extract = XLEN'($signed(sh_h[15:0]));
        3'b101: extract = XLEN'(sh_h[15:0]);
        // On a 32-bit datapath these are plain LW and keep the full word.
        3'b010: if (XLEN == 64) extract = XLEN'($signed(sh_w[31:0]));
        3'b110: if (XLEN == 64) extract = XLEN'(sh_w[31:0]);
        default: extract = e.data;
      endcase
    end
  endfunction

  // NOTE: FIFO storage has no reset; validity is carried entirely by the pointers and counts.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_SRC; i++) begin
      if (push[i]) begin
        mem[i][wr_ptr[i]] <= '{rd:      bus.src_rd[i],
                               data:    bus.src_data[i],
                               is_load: bus.src_is_load[i],
                               funct3:  bus.src_funct3[i],
                               off:     bus.src_off[i]};
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        count[i]  <= '0;
      end
      rr_ptr <= '0;
      we_q   <= 1'b0;
      rd_q   <= '0;
      data_q <= '0;
    end else if (flush) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        count[i]  <= '0;
      end
      we_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + PTRW'(1);
        if (pop[i])  rd_ptr[i] <= rd_ptr[i] + PTRW'(1);
        case ({push[i], pop[i]})
          2'b10:   count[i] <= count[i] + CNTW'(1);
          2'b01:   count[i] <= count[i] - CNTW'(1);
          default: count[i] <= count[i];
        endcase
      end
      we_q <= grant_valid && (head.rd != 5'd0);
      if (grant_valid) begin
        rr_ptr <= (grant_idx == LAST_SRC) ? '0 : grant_idx + RRW'(1);
        rd_q   <= head.rd;
        data_q <= extract(head);
      end
    end
  end

  assign bus.rf_we   = we_q;
  assign bus.rf_rd   = rd_q;
  assign bus.rf_data = data_q;
endmodule

// File: tb/tb_wb_merge.sv
// Scoreboard bench for wb_merge: expected writes queue per source (rd[4] tags the source)
// and are popped whenever rf_we is seen; scenario tasks add inline timing checks.
module tb_wb_merge;
  localparam int XLEN    = 32;
  localparam int NUM_SRC = 2;
  localparam int DEPTH   = 2;
  localparam int N_B2B   = 10;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  int   errors = 0;
  int   checks = 0;
  exp_t sb0[$];
  exp_t sb1[$];
  int   grants[$];

  logic [2:0]  ld_f3  [12] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b000, 3'b001,
                              3'b100, 3'b010, 3'b011, 3'b110, 3'b111, 3'b000};
  logic [1:0]  ld_off [12] = '{2'd3, 2'd1, 2'd2, 2'd3, 2'd0, 2'd0,
                              2'd2, 2'd2, 2'd0, 2'd1, 2'd0, 2'd3};
  logic        ld_en  [12] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
                              1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  logic [31:0] ld_exp [12] = '{32'hFFFF_FF80, 32'h0000_007F, 32'hFFFF_80FF, 32'h0000_80FF,
                              32'h0000_0001, 32'h0000_7F01, 32'h0000_00FF, 32'h80FF_7F01,
                              32'h80FF_7F01, 32'h80FF_7F01, 32'h80FF_7F01, 32'h80FF_7F01};

  wb_merge_if #(.XLEN(XLEN), .NUM_SRC(NUM_SRC)) bus();

  wb_merge #(.XLEN(XLEN), .NUM_SRC(NUM_SRC), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] rd_of(input int s, input int i);
    return (s == 0) ? 5'(1 + i % 15) : 5'(16 + i % 16);
  endfunction

  function automatic logic [31:0] tag_of(input int s, input int i);
    return 32'hA000_0000 | 32'(s << 16) | 32'(i);
  endfunction

  task automatic idle();
    bus.src_valid   = '0;
    bus.src_rd      = '0;
    bus.src_data    = '0;
    bus.src_is_load = '0;
    bus.src_funct3  = '0;
    bus.src_off     = '0;
  endtask

  task automatic set_src(input int s, input logic v, input logic [4:0] rd, input logic [31:0] data,
                         input logic ld, input logic [2:0] f3, input logic [1:0] off);
    bus.src_valid[s]   = v;
    bus.src_rd[s]      = rd;
    bus.src_data[s]    = data;
    bus.src_is_load[s] = ld;
    bus.src_funct3[s]  = f3;
    bus.src_off[s]     = off;
  endtask

  task automatic expect_wr(input int s, input logic [4:0] rd, input logic [31:0] data);
    if (s == 0) sb0.push_back('{rd: rd, data: data});
    else        sb1.push_back('{rd: rd, data: data});
  endtask

  // One clock: inputs are sampled at the rising edge, outputs observed at the following falling edge.
  task automatic cycle();
    exp_t e;
    int   s;
    @(posedge clk);
    @(negedge clk);
    if (bus.rf_we === 1'b1) begin
      s = int'(bus.rf_rd[4]);
      grants.push_back(s);
      checks++;
      if ((s == 0 && sb0.size() == 0) || (s == 1 && sb1.size() == 0)) begin
        errors++;
        $display("FAIL unexpected_write: got rd=%0d data=%h, required no write", bus.rf_rd, bus.rf_data);
      end else begin
        e = (s == 0) ? sb0.pop_front() : sb1.pop_front();
        if (bus.rf_rd !== e.rd || bus.rf_data !== e.data) begin
          errors++;
          $display("FAIL scoreboard_src%0d: got rd=%0d data=%h, required rd=%0d data=%h",
                   s, bus.rf_rd, bus.rf_data, e.rd, e.data);
        end
      end
    end
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((sb0.size() + sb1.size()) > 0 && n < budget) begin
      cycle();
      n++;
    end
    checks++;
    if ((sb0.size() + sb1.size()) != 0) begin
      errors++;
      $display("FAIL drain_timeout: got %0d entries outstanding, required 0", sb0.size() + sb1.size());
      sb0.delete();
      sb1.delete();
    end
    repeat (2) cycle();
  endtask

  task automatic apply_reset();
    rst   = 1'b0;
    flush = 1'b0;
    idle();
    sb0.delete();
    sb1.delete();
    grants.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    idle();
    flush = 1'b0;
    rst   = 1'b1;
    #1 rst = 1'b0;
    #2;
    checks += 4;
    if (bus.rf_we !== 1'b0) begin errors++; $display("FAIL reset_we: got %b required 0", bus.rf_we); end
    if (bus.rf_rd !== 5'd0) begin errors++; $display("FAIL reset_rd: got %0d required 0", bus.rf_rd); end
    if (bus.rf_data !== 32'd0) begin errors++; $display("FAIL reset_data: got %h required 0", bus.rf_data); end
    if (bus.src_ready !== 2'b11) begin errors++; $display("FAIL reset_ready: got %b required 11", bus.src_ready); end
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_alu();
    set_src(0, 1'b1, 5'd5, 32'h1234_5678, 1'b0, 3'b000, 2'd0);
    expect_wr(0, 5'd5, 32'h1234_5678);
    cycle();
    idle();
    checks++;
    if (bus.rf_we !== 1'b0) begin errors++; $display("FAIL alu_latency_early: got we=%b required 0", bus.rf_we); end
    cycle();
    checks++;
    if (bus.rf_we !== 1'b1 || bus.rf_rd !== 5'd5 || bus.rf_data !== 32'h1234_5678) begin
      errors++;
      $display("FAIL alu_write: got we=%b rd=%0d data=%h required we=1 rd=5 data=12345678",
               bus.rf_we, bus.rf_rd, bus.rf_data);
    end
    drain(10);
  endtask

  task automatic test_load();
    for (int i = 0; i < 12; i++) begin
      set_src(0, 1'b1, 5'(i + 1), 32'h80FF_7F01, ld_en[i], ld_f3[i], ld_off[i]);
      checks++;
      if (bus.src_ready[0] !== 1'b1) begin
        errors++;
        $display("FAIL load_ready_%0d: got %b required 1", i, bus.src_ready[0]);
      end
      expect_wr(0, 5'(i + 1), ld_exp[i]);
      cycle();
    end
    idle();
    drain(20);
  endtask

  task automatic test_back_to_back();
    int         idx [2];
    logic [1:0] v;
    logic [1:0] r;
    int         cyc = 0;
    apply_reset();
    idx[0] = 0;
    idx[1] = 0;
    while ((idx[0] < N_B2B || idx[1] < N_B2B) && cyc < 200) begin
      for (int s = 0; s < 2; s++) begin
        v[s] = (idx[s] < N_B2B);
        set_src(s, v[s], rd_of(s, idx[s]), tag_of(s, idx[s]), 1'b0, 3'b000, 2'd0);
      end
      r = bus.src_ready;
      for (int s = 0; s < 2; s++) begin
        if (v[s] && r[s]) begin
          expect_wr(s, rd_of(s, idx[s]), tag_of(s, idx[s]));
          idx[s]++;
        end
      end
      cycle();
      cyc++;
    end
    idle();
    drain(60);
    checks++;
    if (idx[0] != N_B2B || idx[1] != N_B2B) begin
      errors++;
      $display("FAIL b2b_accept_timeout: got %0d/%0d accepted, required %0d each", idx[0], idx[1], N_B2B);
    end
    checks++;
    if (grants.size() != 2 * N_B2B) begin
      errors++;
      $display("FAIL b2b_write_count: got %0d required %0d", grants.size(), 2 * N_B2B);
    end else begin
      for (int k = 0; k < 6; k++) begin
        checks++;
        if (grants[k] != k % 2) begin
          errors++;
          $display("FAIL b2b_rr_order_%0d: got src%0d required src%0d", k, grants[k], k % 2);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    apply_reset();
    set_src(0, 1'b1, 5'd1, 32'hB0, 1'b0, 3'b000, 2'd0);
    set_src(1, 1'b1, 5'd17, 32'hB1, 1'b0, 3'b000, 2'd0);
    expect_wr(0, 5'd1, 32'hB0);
    expect_wr(1, 5'd17, 32'hB1);
    cycle();
    checks++;
    if (bus.src_ready !== 2'b11) begin errors++; $display("FAIL bp_ready_one: got %b required 11", bus.src_ready); end
    set_src(0, 1'b1, 5'd2, 32'hB2, 1'b0, 3'b000, 2'd0);
    set_src(1, 1'b1, 5'd18, 32'hB3, 1'b0, 3'b000, 2'd0);
    expect_wr(0, 5'd2, 32'hB2);
    expect_wr(1, 5'd18, 32'hB3);
    cycle();
    checks++;
    if (bus.src_ready !== 2'b01) begin errors++; $display("FAIL bp_src1_full: got %b required 01", bus.src_ready); end
    // src1 keeps offering a third entry while full; it must not be taken this edge.
    set_src(0, 1'b1, 5'd3, 32'hB4, 1'b0, 3'b000, 2'd0);
    set_src(1, 1'b1, 5'd19, 32'hB5, 1'b0, 3'b000, 2'd0);
    expect_wr(0, 5'd3, 32'hB4);
    cycle();
    checks++;
    if (bus.src_ready !== 2'b10) begin errors++; $display("FAIL bp_src1_recover: got %b required 10", bus.src_ready); end
    set_src(0, 1'b1, 5'd4, 32'hB6, 1'b0, 3'b000, 2'd0);
    expect_wr(1, 5'd19, 32'hB5);
    cycle();
    idle();
    drain(20);
  endtask

  task automatic test_rd_zero();
    apply_reset();
    set_src(0, 1'b1, 5'd0, 32'hDEAD_0000, 1'b0, 3'b000, 2'd0);
    set_src(1, 1'b1, 5'd20, 32'h0000_0014, 1'b0, 3'b000, 2'd0);
    expect_wr(1, 5'd20, 32'h0000_0014);
    cycle();
    set_src(0, 1'b1, 5'd7, 32'h0000_0077, 1'b0, 3'b000, 2'd0);
    set_src(1, 1'b0, 5'd0, 32'h0, 1'b0, 3'b000, 2'd0);
    expect_wr(0, 5'd7, 32'h0000_0077);
    cycle();
    idle();
    checks++;
    if (bus.rf_we !== 1'b0 || bus.rf_rd !== 5'd0 || bus.rf_data !== 32'hDEAD_0000) begin
      errors++;
      $display("FAIL rd0_popped: got we=%b rd=%0d data=%h required we=0 rd=0 data=dead0000",
               bus.rf_we, bus.rf_rd, bus.rf_data);
    end
    cycle();
    checks++;
    if (bus.rf_we !== 1'b1 || bus.rf_rd !== 5'd20) begin
      errors++;
      $display("FAIL rd0_rr_advance: got we=%b rd=%0d required we=1 rd=20", bus.rf_we, bus.rf_rd);
    end
    cycle();
    checks++;
    if (bus.rf_we !== 1'b1 || bus.rf_rd !== 5'd7) begin
      errors++;
      $display("FAIL rd0_next_src0: got we=%b rd=%0d required we=1 rd=7", bus.rf_we, bus.rf_rd);
    end
    drain(10);
  endtask

  task automatic test_flush();
    apply_reset();
    set_src(0, 1'b1, 5'd2, 32'hF0, 1'b0, 3'b000, 2'd0);
    set_src(1, 1'b1, 5'd17, 32'hF1, 1'b0, 3'b000, 2'd0);
    expect_wr(0, 5'd2, 32'hF0);
    expect_wr(1, 5'd17, 32'hF1);
    cycle();
    set_src(0, 1'b1, 5'd3, 32'hF2, 1'b0, 3'b000, 2'd0);
    set_src(1, 1'b1, 5'd18, 32'hF3, 1'b0, 3'b000, 2'd0);
    expect_wr(0, 5'd3, 32'hF2);
    expect_wr(1, 5'd18, 32'hF3);
    cycle();
    // Three entries are queued; the flush discards them and the offered pair is ignored.
    sb0.delete();
    sb1.delete();
    set_src(0, 1'b1, 5'd9, 32'hF4, 1'b0, 3'b000, 2'd0);
    set_src(1, 1'b1, 5'd25, 32'hF5, 1'b0, 3'b000, 2'd0);
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    idle();
    checks += 2;
    if (bus.rf_we !== 1'b0) begin errors++; $display("FAIL flush_we: got %b required 0", bus.rf_we); end
    if (bus.src_ready !== 2'b11) begin errors++; $display("FAIL flush_ready: got %b required 11", bus.src_ready); end
    for (int i = 0; i < 4; i++) begin
      cycle();
      checks++;
      if (bus.rf_we !== 1'b0) begin errors++; $display("FAIL flush_quiet_%0d: got we=%b required 0", i, bus.rf_we); end
    end
    set_src(0, 1'b1, 5'd4, 32'hF6, 1'b0, 3'b000, 2'd0);
    set_src(1, 1'b1, 5'd19, 32'hF7, 1'b0, 3'b000, 2'd0);
    expect_wr(0, 5'd4, 32'hF6);
    expect_wr(1, 5'd19, 32'hF7);
    cycle();
    idle();
    cycle();
    checks++;
    if (bus.rf_we !== 1'b1 || bus.rf_rd !== 5'd19) begin
      errors++;
      $display("FAIL flush_rr_held: got we=%b rd=%0d required we=1 rd=19", bus.rf_we, bus.rf_rd);
    end
    drain(10);
  endtask

  task automatic test_reset_mid();
    set_src(0, 1'b1, 5'd5, 32'hC0, 1'b0, 3'b000, 2'd0);
    set_src(1, 1'b1, 5'd22, 32'hC1, 1'b0, 3'b000, 2'd0);
    expect_wr(0, 5'd5, 32'hC0);
    expect_wr(1, 5'd22, 32'hC1);
    cycle();
    set_src(0, 1'b1, 5'd6, 32'hC2, 1'b0, 3'b000, 2'd0);
    set_src(1, 1'b1, 5'd23, 32'hC3, 1'b0, 3'b000, 2'd0);
    expect_wr(0, 5'd6, 32'hC2);
    expect_wr(1, 5'd23, 32'hC3);
    cycle();
    rst = 1'b0;
    idle();
    sb0.delete();
    sb1.delete();
    #1;
    checks += 4;
    if (bus.rf_we !== 1'b0) begin errors++; $display("FAIL midrst_we: got %b required 0", bus.rf_we); end
    if (bus.rf_rd !== 5'd0) begin errors++; $display("FAIL midrst_rd: got %0d required 0", bus.rf_rd); end
    if (bus.rf_data !== 32'd0) begin errors++; $display("FAIL midrst_data: got %h required 0", bus.rf_data); end
    if (bus.src_ready !== 2'b11) begin errors++; $display("FAIL midrst_ready: got %b required 11", bus.src_ready); end
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycle();
      checks++;
      if (bus.rf_we !== 1'b0) begin errors++; $display("FAIL midrst_quiet_%0d: got we=%b required 0", i, bus.rf_we); end
    end
    set_src(1, 1'b1, 5'd21, 32'h0000_0021, 1'b0, 3'b000, 2'd0);
    expect_wr(1, 5'd21, 32'h0000_0021);
    cycle();
    idle();
    cycle();
    checks++;
    if (bus.rf_we !== 1'b1 || bus.rf_rd !== 5'd21) begin
      errors++;
      $display("FAIL midrst_restart: got we=%b rd=%0d required we=1 rd=21", bus.rf_we, bus.rf_rd);
    end
    drain(10);
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load();
    test_back_to_back();
    test_backpressure();
    test_rd_zero();
    test_flush();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/wb_merge.md
WB_MERGE -- requirements
Module: wb_merge

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning register/data width (32 or 64).
REQ-002 SHALL have parameter NUM_SRC, default 2, meaning number of completion sources (2..4).
REQ-003 SHALL have parameter DEPTH, default 2, meaning per-source FIFO entries (power of 2, >=2).
REQ-004 SHALL have port clk, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1, meaning the reset; it is asynchronous and active-low.
REQ-006 SHALL have port flush, input, 1, meaning synchronous discard of all queued results.
REQ-007 SHALL have port src_valid, input, NUM_SRC, meaning per-source result valid.
REQ-008 SHALL have port src_ready, output, NUM_SRC, meaning per-source FIFO can accept.
REQ-009 SHALL have port src_rd, input, NUM_SRC x 5, meaning destination register.
REQ-010 SHALL have port src_data, input, NUM_SRC x XLEN, meaning ALU result or raw memory word.
REQ-011 SHALL have port src_is_load, input, NUM_SRC, meaning data needs load extraction.
REQ-012 SHALL have port src_funct3, input, NUM_SRC x 3, meaning load type.
REQ-013 SHALL have port src_off, input, NUM_SRC x log2(XLEN/8), meaning address byte offset.
REQ-014 SHALL have port rf_we, output, 1, meaning regfile write enable.
REQ-015 SHALL have port rf_rd, output, 5, meaning regfile write index.
REQ-016 SHALL have port rf_data, output, XLEN, meaning regfile write data.

Function
REQ-017 SHALL give each source a DEPTH-entry FIFO {rd, data, is_load, funct3, off} with wrapping read/write pointers and an occupancy counter 0..DEPTH.
REQ-018 SHALL drive src_ready[i] high iff FIFO i occupancy < DEPTH, independent of same-cycle pop.
REQ-019 SHALL push FIFO i on an edge where src_valid[i] && src_ready[i] && !flush.
REQ-020 SHALL, each cycle, select at most one non-empty FIFO by round-robin starting at rr_ptr and pop its head.
REQ-021 SHALL set rr_ptr to (granted index + 1) mod NUM_SRC after each grant; rr_ptr holds when nothing is granted.
REQ-022 SHALL, on a simultaneous push and pop of one FIFO, leave its occupancy unchanged and keep data ordered.
REQ-023 SHALL register the granted entry to rf_*: rf_we = 1 iff an entry was granted and its rd != 0; rf_rd/rf_data update with every grant.
REQ-024 SHALL give a latency of 2 edges: input accepted at edge E into an empty, granted FIFO yields rf_we high after edge E+1.
REQ-025 SHALL pass data unchanged when is_load = 0.
REQ-026 SHALL, when is_load = 1, extract at byte offset off: funct3 000 LB sign-extended byte; 100 LBU zero-extended byte; 001 LH and 101 LHU sign/zero-extended halfword at off with bit0 forced 0; 010 LW full word for XLEN = 32.
REQ-027 SHALL, when XLEN = 64, treat 010 as a sign-extended word and 110 LWU as a zero-extended word, both at off with bits[1:0] forced 0, and 011 LD as the full doubleword.
REQ-028 SHALL, when XLEN = 32, treat funct3 011 and 110 as LW, and any other unlisted funct3 as pass-through.
REQ-029 SHALL, when flush = 1, clear every FIFO pointer and occupancy, suppress that cycle's grant, and force rf_we = 0 at the next edge; rr_ptr is held.
REQ-030 SHALL ignore src_valid while flush = 1.

Reset
REQ-031 SHALL, while rst = 0, asynchronously clear FIFO pointers and occupancies, set rr_ptr = 0, and drive rf_we = 0, rf_rd = 0, rf_data = 0.
REQ-032 SHALL drive src_ready to all ones during and after reset; reset asserted mid-stream discards all queued entries.
REQ-033 SHALL accept its first push on the first rising edge after rst returns to 1.

Verification
REQ-034 Bench SHALL check: src0 ALU, rd = 5, data 0x1234_5678 -> two edges later rf_we = 1, rf_rd = 5, rf_data = 0x1234_5678.
REQ-035 Bench SHALL check: load with data 0x80FF_7F01, funct3 LB, off 3 -> rf_data 0xFFFF_FF80; LBU off 1 -> 0x0000_007F; LH off 2 -> 0xFFFF_80FF.
REQ-036 Bench SHALL check: both sources valid every cycle from reset -> grants alternate src0, src1, src0; no entry lost; per-source order kept.
REQ-037 Bench SHALL check: src1 pushed DEPTH times with src0 saturating arbitration -> src_ready[1] = 0 when occupancy = DEPTH, then recovers after a src1 grant.
REQ-038 Bench SHALL check: rd = 0 result -> popped and rr_ptr advances, rf_we stays 0.
REQ-039 Bench SHALL check: flush with 3 entries queued, or rst low mid-stream -> no further rf_we until new pushes; occupancies read 0.
